// File: rtl/fir_decim_sched.sv
// Decimating FIR sequencer: fills a tap delay line from an input FIFO, runs one
// shared MAC over all taps against a coefficient ROM, then pushes one result.
module fir_decim_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = 32,
    parameter int DECIMATION = 8,
    parameter int QUANT_BITS = 10,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [ADDR_WIDTH-1:0] coeff_addr,
    input  logic [DATA_WIDTH-1:0] coeff_data,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DECIMATION + 1);
    localparam int PW    = DATA_WIDTH + QUANT_BITS;
    localparam logic [CNT_W-1:0]      LAST_COUNT = CNT_W'(DECIMATION - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_TAP   = ADDR_WIDTH'(TAPS - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_MAC,
        S_WRITE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] dline_q [TAPS];
    logic [DATA_WIDTH-1:0] dline_d [TAPS];
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] tap_q, tap_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] out_din_q, out_din_d;

    logic signed [PW-1:0]  coeff_ext;
    logic signed [PW-1:0]  sample_ext;
    logic signed [PW-1:0]  product;
    logic [DATA_WIDTH-1:0] scaled;
    logic [DATA_WIDTH-1:0] mac_sum;
    logic                  unused_frac;

    assign in_rd_en   = !reset && (state_q == S_FILL) && !in_empty;
    assign out_wr_en  = !reset && (state_q == S_WRITE) && !out_full;
    assign busy       = !reset && (state_q != S_FILL);
    assign coeff_addr = (state_q == S_MAC) ? tap_q : '0;
    assign out_din    = out_din_q;

    // Only the low DATA_WIDTH+QUANT_BITS bits of the full product survive the
    // floor shift and the wrap to DATA_WIDTH, so the multiply is done that wide.
    assign coeff_ext   = PW'($signed(coeff_data));
    assign sample_ext  = PW'($signed(dline_q[tap_q]));
    assign product     = coeff_ext * sample_ext;
    assign scaled      = product[PW-1:QUANT_BITS];
    assign unused_frac = ^product[QUANT_BITS-1:0];
    assign mac_sum     = acc_q + scaled;

    always_comb begin
        state_d   = state_q;
        dline_d   = dline_q;
        count_d   = count_q;
        tap_d     = tap_q;
        acc_d     = acc_q;
        out_din_d = out_din_q;
        case (state_q)
            S_FILL: begin
                if (in_rd_en) begin
                    for (int k = TAPS - 1; k > 0; k--) begin
                        dline_d[k] = dline_q[k-1];
                    end
                    dline_d[0] = in_dout;
                    if (count_q == LAST_COUNT) begin
                        count_d = '0;
                        state_d = S_MAC;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            S_MAC: begin
                acc_d = mac_sum;
                if (tap_q == LAST_TAP) begin
                    out_din_d = mac_sum;
                    state_d   = S_WRITE;
                end else begin
                    tap_d = tap_q + ADDR_WIDTH'(1);
                end
            end
            S_WRITE: begin
                // Holding here under backpressure keeps acc and out_din untouched.
                if (out_wr_en) begin
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FILL;
            dline_q   <= '{default: '0};
            count_q   <= '0;
            tap_q     <= '0;
            acc_q     <= '0;
            out_din_q <= '0;
        end else begin
            state_q   <= state_d;
            dline_q   <= dline_d;
            count_q   <= count_d;
            tap_q     <= tap_d;
            acc_q     <= acc_d;
            out_din_q <= out_din_d;
        end
    end

endmodule

// File: tb/tb_fir_decim_sched.sv
// Directed self-checking bench for fir_decim_sched with a FIFO source model,
// a combinational coefficient ROM model and an output capture list.
module tb_fir_decim_sched;

    localparam int W    = 32;
    localparam int TAPS = 32;
    localparam int AW   = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  in_dout;
    logic          in_empty;
    logic          in_rd_en;
    logic [AW-1:0] coeff_addr;
    logic [W-1:0]  coeff_data;
    logic [W-1:0]  out_din;
    logic          out_full;
    logic          out_wr_en;
    logic          busy;

    logic [W-1:0] in_mem    [0:255];
    logic [W-1:0] coeff_mem [0:TAPS-1];
    logic [W-1:0] res       [0:63];
    int           wr_cyc    [0:63];
    int           pop_cyc   [0:255];
    int           rd_ptr = 0;
    int           wr_ptr = 0;
    int           res_n = 0;
    int           pop_n = 0;
    int           cyc = 0;
    logic         starve = 1'b0;
    int           total = 0;
    int           bad = 0;

    logic          s_rd, s_wr, s_busy;
    logic [AW-1:0] s_addr;
    logic [W-1:0]  s_dout;

    always #5 clock = ~clock;

    // Source FIFO model: first-word-fall-through, optionally starved on odd cycles.
    assign in_empty   = (rd_ptr >= wr_ptr) || (starve && cyc[0]);
    assign in_dout    = (rd_ptr < wr_ptr) ? in_mem[rd_ptr[7:0]] : '0;
    assign coeff_data = coeff_mem[coeff_addr];

    fir_decim_sched dut (
        .clock      (clock),
        .reset      (reset),
        .in_dout    (in_dout),
        .in_empty   (in_empty),
        .in_rd_en   (in_rd_en),
        .coeff_addr (coeff_addr),
        .coeff_data (coeff_data),
        .out_din    (out_din),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en),
        .busy       (busy)
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Sample on the falling edge, let the DUT act on the rising edge, then
    // retire any pop so the FIFO head advances.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            s_rd   = in_rd_en;
            s_wr   = out_wr_en;
            s_busy = busy;
            s_addr = coeff_addr;
            s_dout = out_din;
            if (s_rd && pop_n < 256) begin
                pop_cyc[pop_n] = cyc;
                pop_n++;
            end
            if (s_wr && res_n < 64) begin
                res[res_n]    = s_dout;
                wr_cyc[res_n] = cyc;
                res_n++;
            end
            @(posedge clock);
            #1;
            if (s_rd) rd_ptr++;
            cyc++;
        end
    endtask

    task automatic loadSamples(input logic [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            in_mem[wr_ptr[7:0]] = v;
            wr_ptr++;
        end
    endtask

    task automatic setCoeffs(input int mode);
        for (int k = 0; k < TAPS; k++) begin
            if (mode == 0)      coeff_mem[k] = 32'd1024;
            else if (mode == 1) coeff_mem[k] = W'((k + 1) << 10);
            else                coeff_mem[k] = 32'd1;
        end
    endtask

    task automatic doReset();
        reset    = 1'b1;
        out_full = 1'b0;
        starve   = 1'b0;
        rd_ptr   = 0;
        wr_ptr   = 0;
        applyStimulus(2);
        reset = 1'b0;
        res_n = 0;
        pop_n = 0;
    endtask

    task automatic waitOutputs(input string tag, input int n, input int budget);
        int b;
        b = 0;
        while (res_n < n && b < budget) begin
            applyStimulus(1);
            b++;
        end
        checkOutput(tag, res_n, n);
    endtask

    initial begin
        int b;
        out_full = 1'b0;

        // Reset state with data waiting: nothing may be read or written
        setCoeffs(0);
        loadSamples(32'd1, 32);
        reset = 1'b1;
        applyStimulus(2);
        checkOutput("rst_rd_en", s_rd, 0);
        checkOutput("rst_wr_en", s_wr, 0);
        checkOutput("rst_busy", s_busy, 0);
        checkOutput("rst_addr", s_addr, 0);
        checkOutput("rst_out_din", out_din, 0);
        checkOutput("rst_no_pop", rd_ptr, 0);
        reset = 1'b0;

        // Unit DC gain: ramp 8,16,24,32 and 33-cycle latency after the 8th read
        waitOutputs("dc_count", 4, 400);
        for (int j = 0; j < 4; j++) checkOutput($sformatf("dc_out%0d", j), res[j], W'(8 * (j + 1)));
        checkOutput("dc_latency", W'(wr_cyc[0] - pop_cyc[7]), 33);

        // Impulse lands on tap 7 then tap 15
        doReset();
        setCoeffs(1);
        loadSamples(32'd1, 1);
        loadSamples(32'd0, 15);
        waitOutputs("imp_count", 2, 300);
        checkOutput("imp_out0", res[0], 8);
        checkOutput("imp_out1", res[1], 16);

        // Floor rounding of negative products
        doReset();
        setCoeffs(2);
        loadSamples(32'hFFFF_FFFF, 8);
        waitOutputs("floor_count", 1, 200);
        checkOutput("floor_out", res[0], 32'hFFFF_FFF8);

        // Output backpressure for 5 cycles in S_WRITE
        doReset();
        setCoeffs(0);
        out_full = 1'b1;
        loadSamples(32'd1, 16);
        b = 0;
        s_dout = '0;
        while (s_dout != 32'd8 && b < 200) begin
            applyStimulus(1);
            b++;
        end
        checkOutput("bp_enter", s_dout, 8);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_wr_en%0d", i), s_wr, 0);
            checkOutput($sformatf("bp_rd_en%0d", i), s_rd, 0);
            checkOutput($sformatf("bp_dout%0d", i), s_dout, 8);
            if (i < 4) applyStimulus(1);
        end
        out_full = 1'b0;
        applyStimulus(1);
        checkOutput("bp_release_wr", s_wr, 1);
        checkOutput("bp_release_dout", s_dout, 8);
        applyStimulus(1);
        checkOutput("bp_refill_busy", s_busy, 0);
        checkOutput("bp_refill_rd", s_rd, 1);
        waitOutputs("bp_count", 2, 200);
        checkOutput("bp_out1", res[1], 16);

        // Starved input: 100 samples give 12 outputs with no inserted zeros
        doReset();
        setCoeffs(0);
        starve = 1'b1;
        loadSamples(32'd1, 100);
        applyStimulus(1500);
        starve = 1'b0;
        checkOutput("starve_count", res_n, 12);
        for (int j = 0; j < 12; j++) begin
            checkOutput($sformatf("starve_out%0d", j), res[j], (j < 3) ? W'(8 * (j + 1)) : 32'd32);
        end
        checkOutput("starve_consumed", rd_ptr, 100);

        // Reset during MAC tap 10 discards the result and clears the delay line
        doReset();
        setCoeffs(0);
        loadSamples(32'd1, 8);
        b = 0;
        s_busy = 1'b0;
        s_addr = '0;
        while (!(s_busy && s_addr == 5'd9) && b < 100) begin
            applyStimulus(1);
            b++;
        end
        checkOutput("mr_reach", s_addr, 9);
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        applyStimulus(1);
        checkOutput("mr_busy", s_busy, 0);
        checkOutput("mr_wr_en", s_wr, 0);
        checkOutput("mr_addr", s_addr, 0);
        loadSamples(32'd1, 8);
        waitOutputs("mr_count", 1, 200);
        checkOutput("mr_out", res[0], 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
